// File: rtl/ook_pkg.sv
// ook_pkg: shared definitions for the OOK receive path.
//   ook_state_e  - demodulator FSM states (IDLE, RUN)
//   OOK_MID      - ADC code for zero carrier
//   OOK_MAG_W    - rectified magnitude width
//   ook_mag_f()  - rectifier, reusable by other OOK blocks
package ook_pkg;

  localparam logic [7:0] OOK_MID   = 8'd128;
  localparam int         OOK_MAG_W = 7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ook_state_e;

  // adc >= 128 is exactly adc[7]=1, so adc-128 is adc[6:0]; below mid-scale
  // 127-adc is the bitwise inverse of adc[6:0]. Range is 0..127 either way.
  function automatic logic [OOK_MAG_W-1:0] ook_mag_f(input logic [7:0] s);
    return s[7] ? s[6:0] : ~s[6:0];
  endfunction

endpackage

// File: rtl/ook_mag.sv
// ook_mag: combinational rectifier for unsigned ADC samples around OOK_MID.
//   adc_i [7:0]  unsigned sample
//   mag_o [6:0]  |sample - mid-scale|, 0..127
module ook_mag
  import ook_pkg::*;
(
  input  logic [7:0]           adc_i,
  output logic [OOK_MAG_W-1:0] mag_o
);

  assign mag_o = ook_mag_f(adc_i);

endmodule

// File: rtl/ook_demod.sv
// ook_demod: on-off-keying demodulator. Rectifies ADC samples, integrates
// magnitude over SPB-sample windows and slices each window against bit_thr.
//   clk, rst          clock, synchronous active-low reset
//   sample_valid, adc sample stream (one sample per valid cycle)
//   det_thr           per-sample magnitude needed to detect carrier start
//   bit_thr           window-sum threshold (bits above ACC_W must be zero)
//   bit_out/bit_valid recovered bit and its one-cycle strobe
//   carrier_det       high while a carrier is being demodulated (RUN)
// Build option: OOK_DEMOD_DEGLITCH_EN - require 4 consecutive hits to start.
module ook_demod
  import ook_pkg::*;
#(
  parameter  int SPB        = 64,
  parameter  int ZERO_LIMIT = 8,
  localparam int ACC_W      = OOK_MAG_W + $clog2(SPB)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [7:0]  adc,
  input  logic [6:0]  det_thr,
  input  logic [15:0] bit_thr,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        carrier_det
);

  localparam int CNT_W = $clog2(SPB);
  localparam int ZR_W  = 8;

  ook_state_e             state_q, state_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ZR_W-1:0]        zr_q, zr_d;
  logic                   bit_q, bit_d;
  logic                   vld_q, vld_d;

  logic [OOK_MAG_W-1:0]   mag;
  logic [ACC_W-1:0]       sum;
  logic                   last, hit, win_bit;

  ook_mag u_mag (
    .adc_i (adc),
    .mag_o (mag)
  );

  assign sum     = acc_q + ACC_W'(mag);
  assign last    = (cnt_q == CNT_W'(SPB - 1));
  assign hit     = (mag >= det_thr);
  // 17-bit compare keeps this legal even when ACC_W reaches 16.
  assign win_bit = (17'(sum) >= 17'(bit_thr));

`ifdef OOK_DEMOD_DEGLITCH_EN
  logic [1:0] hit_q, hit_d;   // consecutive start hits seen so far
  logic [8:0] pre_q, pre_d;   // sum of those hits' magnitudes (<= 3*127)
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    zr_d    = zr_q;
    bit_d   = bit_q;
    vld_d   = 1'b0;
`ifdef OOK_DEMOD_DEGLITCH_EN
    hit_d   = hit_q;
    pre_d   = pre_q;
`endif
    if (sample_valid) begin
      case (state_q)
        ST_IDLE: begin
`ifdef OOK_DEMOD_DEGLITCH_EN
          if (hit) begin
            if (hit_q == 2'd3) begin
              // Fourth hit: the first hit becomes window sample 0.
              state_d = ST_RUN;
              acc_d   = ACC_W'(pre_q) + ACC_W'(mag);
              cnt_d   = CNT_W'(4);
              hit_d   = 2'd0;
              pre_d   = 9'd0;
            end else begin
              hit_d = hit_q + 2'd1;
              pre_d = pre_q + 9'(mag);
            end
          end else begin
            hit_d = 2'd0;
            pre_d = 9'd0;
          end
`else
          if (hit) begin
            state_d = ST_RUN;
            acc_d   = ACC_W'(mag);
            cnt_d   = CNT_W'(1);
          end
`endif
        end
        ST_RUN: begin
          if (last) begin
            vld_d = 1'b1;
            bit_d = win_bit;
            acc_d = '0;
            cnt_d = '0;
            if (win_bit) begin
              zr_d = '0;
            end else if (zr_q == ZR_W'(ZERO_LIMIT - 1)) begin
              // This zero completes the run: carrier lost.
              zr_d    = '0;
              state_d = ST_IDLE;
            end else begin
              zr_d = zr_q + 1'b1;
            end
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      zr_q    <= '0;
      bit_q   <= 1'b0;
      vld_q   <= 1'b0;
`ifdef OOK_DEMOD_DEGLITCH_EN
      hit_q   <= 2'd0;
      pre_q   <= 9'd0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      zr_q    <= zr_d;
      bit_q   <= bit_d;
      vld_q   <= vld_d;
`ifdef OOK_DEMOD_DEGLITCH_EN
      hit_q   <= hit_d;
      pre_q   <= pre_d;
`endif
    end
  end

  assign bit_out     = bit_q;
  assign bit_valid   = vld_q;
  assign carrier_det = (state_q == ST_RUN);

endmodule
